// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter with a programmable terminal value.
// Supports wrap or saturate at the bounds, a prescaled step enable and a
// parallel load. It produces a one-cycle terminal-count pulse and a sticky
// wrap flag.
// The count range is 0..limit. A count left above limit (for example after
// limit is lowered) is pulled back to limit or wrapped on the next step.
module updown_mod_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  wrap_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  wrapped
);

    logic [WIDTH-1:0]      count_reg, count_next;
    logic [PRESCALE_W-1:0] prescaler_reg, prescaler_next;
    logic                  tc_reg, tc_next;
    logic                  wrapped_reg, wrapped_next;

    logic [WIDTH-1:0]      step_value;
    logic [WIDTH-1:0]      terminal;
    logic [WIDTH-1:0]      load_clamped;
    logic                  step_wraps;
    logic                  step;

    // A load takes priority over a step that falls due in the same cycle.
    assign step         = enable & ~load & (prescaler_reg == prescale);
    assign terminal     = up_down ? limit : '0;
    assign load_clamped = (load_value > limit) ? limit : load_value;

    // Value the counter would take on a step, and whether that step wraps.
    always_comb begin
        step_value = count_reg;
        step_wraps = 1'b0;
        if (up_down) begin
            if (count_reg < limit) begin
                step_value = count_reg + WIDTH'(1);
            end else if (sat_mode) begin
                step_value = limit;
            end else begin
                step_value = '0;
                step_wraps = 1'b1;
            end
        end else begin
            if (count_reg > limit) begin
                step_value = limit;
            end else if (count_reg != '0) begin
                step_value = count_reg - WIDTH'(1);
            end else if (!sat_mode) begin
                step_value = limit;
                step_wraps = 1'b1;
            end else begin
                step_value = '0;
            end
        end
    end

    // Next-state selection. Priority is load, then step, then hold.
    // The pulse fires only when the step moved the count onto the terminal
    // value or wrapped onto it. A saturated hold therefore does not re-pulse.
    always_comb begin
        count_next     = count_reg;
        prescaler_next = prescaler_reg;
        tc_next        = 1'b0;
        wrapped_next   = wrapped_reg;
        if (load) begin
            count_next     = load_clamped;
            prescaler_next = '0;
        end else if (enable) begin
            if (step) begin
                prescaler_next = '0;
                count_next     = step_value;
                tc_next        = (step_value == terminal) &&
                                 ((step_value != count_reg) || step_wraps);
            end else begin
                // Modulo wrap is intentional when prescale drops below
                // the running prescaler value.
                prescaler_next = prescaler_reg + PRESCALE_W'(1);
            end
        end
        if (step && step_wraps) begin
            wrapped_next = 1'b1;
        end else if (wrap_clr) begin
            wrapped_next = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= '0;
            prescaler_reg <= '0;
            tc_reg        <= 1'b0;
            wrapped_reg   <= 1'b0;
        end else begin
            count_reg     <= count_next;
            prescaler_reg <= prescaler_next;
            tc_reg        <= tc_next;
            wrapped_reg   <= wrapped_next;
        end
    end

    assign count    = count_reg;
    assign tc_pulse = tc_reg;
    assign wrapped  = wrapped_reg;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter. It runs a vector table, then hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_updown_mod_counter;

    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    logic                  clk = 1'b0;
    logic                  reset, enable, up_down, sat_mode, load, wrap_clr;
    logic [WIDTH-1:0]      limit, load_value;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc_pulse, wrapped;

    int n_checks = 0;
    int n_fail   = 0;

    updown_mod_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .sat_mode(sat_mode), .limit(limit), .prescale(prescale),
        .load(load), .load_value(load_value), .wrap_clr(wrap_clr),
        .count(count), .tc_pulse(tc_pulse), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, ud, sat;
        logic [7:0] lim;
        logic [3:0] ps;
        logic       ld;
        logic [7:0] lv;
        logic       wc;
        int         exp_count;
        int         exp_tc;
        int         exp_wr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, en, ud, sat, input int lim, ps,
                           input logic ld, input int lv, input logic wc,
                           input int ec, etc, ewr);
        vec_t v;
        v.rst = rst; v.en = en; v.ud = ud; v.sat = sat;
        v.lim = 8'(lim); v.ps = 4'(ps); v.ld = ld; v.lv = 8'(lv); v.wc = wc;
        v.exp_count = ec; v.exp_tc = etc; v.exp_wr = ewr;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic rst, en, ud, sat, input int lim, ps,
                          input logic ld, input int lv, input logic wc);
        reset = rst; enable = en; up_down = ud; sat_mode = sat;
        limit = 8'(lim); prescale = 4'(ps); load = ld; load_value = 8'(lv);
        wrap_clr = wc;
    endtask

    // Sample one time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int ec, etc, ewr);
        chk({name, ".count"}, int'(count), ec);
        chk({name, ".tc_pulse"}, int'(tc_pulse), etc);
        chk({name, ".wrapped"}, int'(wrapped), ewr);
    endtask

    // Behavioural reference model, advanced once per clock edge.
    int m_count, m_pre, m_tc, m_wr;

    task automatic model_edge();
        int  nv, term;
        bit  wrap;
        wrap = 0;
        if (reset) begin
            m_count = 0; m_pre = 0; m_tc = 0; m_wr = 0;
            return;
        end
        m_tc = 0;
        if (load) begin
            m_count = (int'(load_value) < int'(limit)) ? int'(load_value) : int'(limit);
            m_pre   = 0;
        end else if (enable) begin
            if (m_pre == int'(prescale)) begin
                m_pre = 0;
                if (up_down) begin
                    term = int'(limit);
                    if (m_count < int'(limit))  nv = m_count + 1;
                    else if (sat_mode)          nv = int'(limit);
                    else begin nv = 0; wrap = 1; end
                end else begin
                    term = 0;
                    if (m_count > int'(limit))  nv = int'(limit);
                    else if (m_count > 0)       nv = m_count - 1;
                    else if (sat_mode)          nv = 0;
                    else begin nv = int'(limit); wrap = 1; end
                end
                m_tc    = ((nv == term) && (nv != m_count || wrap)) ? 1 : 0;
                m_count = nv;
            end else begin
                m_pre = (m_pre + 1) % (1 << PRESCALE_W);
            end
        end
        if (wrap)          m_wr = 1;
        else if (wrap_clr) m_wr = 0;
    endtask

    initial begin
        int pulses;
        set_in(1, 0, 1, 0, 9, 0, 0, 0, 0);

        // Table: wrap up 0..9,0 then wrap down from a load of 2.
        add_vec(1, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            add_vec(0, 1, 1, 0, 9, 0, 0, 0, 0, i, (i == 9) ? 1 : 0, 0);
        add_vec(0, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 1, 1, 0, 9, 0, 0, 0, 0, 1, 0, 1);
        add_vec(0, 1, 0, 0, 9, 0, 1, 2, 1, 2, 0, 0);
        add_vec(0, 1, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0);
        add_vec(0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0);
        add_vec(0, 1, 0, 0, 9, 0, 0, 0, 0, 9, 0, 1);
        add_vec(0, 1, 0, 0, 9, 0, 0, 0, 1, 8, 0, 0);

        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].sat, int'(vecs[i].lim),
                   int'(vecs[i].ps), vecs[i].ld, int'(vecs[i].lv), vecs[i].wc);
            tick();
            $display("vec %0d: count=%0d tc=%0d wrapped=%0d", i, count, tc_pulse, wrapped);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_wr);
        end

        // Saturating up then down, limit 5.
        set_in(0, 1, 1, 1, 5, 0, 1, 0, 1);
        tick();
        chk("sat_load", int'(count), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1, 1, 1, 5, 0, 0, 0, 0);
            tick();
            pulses += int'(tc_pulse);
        end
        $display("sat up: count=%0d pulses=%0d wrapped=%0d", count, pulses, wrapped);
        chk("sat_up_count", int'(count), 5);
        chk("sat_up_pulses", pulses, 1);
        chk("sat_up_wrapped", int'(wrapped), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1, 0, 1, 5, 0, 0, 0, 0);
            tick();
            pulses += int'(tc_pulse);
        end
        $display("sat down: count=%0d pulses=%0d wrapped=%0d", count, pulses, wrapped);
        chk("sat_dn_count", int'(count), 0);
        chk("sat_dn_pulses", pulses, 1);
        chk("sat_dn_wrapped", int'(wrapped), 0);

        // Prescale 3: a step every 4 enabled cycles, frozen while enable is low.
        set_in(0, 1, 1, 0, 100, 3, 1, 0, 0);
        tick();
        set_in(0, 1, 1, 0, 100, 3, 0, 0, 0);
        tick(); tick(); tick();
        chk("ps_before_step", int'(count), 0);
        tick();
        chk("ps_first_step", int'(count), 1);
        tick(); tick();
        set_in(0, 0, 1, 0, 100, 3, 0, 0, 0);
        tick(); tick();
        chk("ps_frozen", int'(count), 1);
        set_in(0, 1, 1, 0, 100, 3, 0, 0, 0);
        tick();
        chk("ps_delayed", int'(count), 1);
        tick();
        $display("prescale: count=%0d", count);
        chk("ps_second_step", int'(count), 2);

        // Load clamp, load beating a due step, lowered limit.
        set_in(0, 1, 1, 0, 100, 3, 1, 200, 0);
        tick();
        chk("load_clamp", int'(count), 100);
        set_in(0, 1, 1, 0, 100, 3, 0, 0, 0);
        tick(); tick();
        set_in(0, 1, 1, 0, 100, 2, 1, 10, 0);
        tick();
        chk("load_wins", int'(count), 10);
        set_in(0, 1, 1, 0, 100, 2, 0, 0, 0);
        tick();
        chk("pre_cleared_a", int'(count), 10);
        tick();
        chk("pre_cleared_b", int'(count), 10);
        tick();
        chk("pre_cleared_step", int'(count), 11);
        set_in(0, 1, 1, 0, 100, 0, 1, 80, 1);
        tick();
        chk_all("load80", 80, 0, 0);
        set_in(0, 1, 1, 0, 50, 0, 0, 0, 0);
        tick();
        $display("limit lowered: count=%0d wrapped=%0d", count, wrapped);
        chk_all("limit_lowered", 0, 0, 1);

        // Reset while tc_pulse is high.
        set_in(0, 1, 1, 0, 7, 0, 1, 6, 0);
        tick();
        set_in(0, 1, 1, 0, 7, 0, 0, 0, 0);
        tick();
        chk_all("at_tc7", 7, 1, 1);
        set_in(1, 1, 1, 0, 7, 0, 0, 0, 0);
        tick();
        chk_all("reset", 0, 0, 0);
        set_in(0, 1, 1, 0, 7, 0, 0, 0, 0);
        tick();
        chk_all("resume", 1, 0, 0);

        // limit 0 in wrap mode, with a wrap and wrap_clr in the same cycle.
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 1);
        tick();
        $display("limit0: count=%0d tc=%0d wrapped=%0d", count, tc_pulse, wrapped);
        chk_all("limit0_wrap", 0, 1, 1);

        // Randomized traffic against the model.
        set_in(1, 0, 1, 0, 9, 0, 0, 0, 0);
        model_edge();
        tick();
        chk_all("rand_reset", m_count, m_tc, m_wr);
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            enable   = ($urandom_range(0, 99) < 85);
            load     = ($urandom_range(0, 99) < 4);
            wrap_clr = ($urandom_range(0, 99) < 10);
            load_value = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 10) up_down = ~up_down;
            if ($urandom_range(0, 99) < 5)  sat_mode = ~sat_mode;
            if ($urandom_range(0, 99) < 5)  prescale = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5)
                limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 12));
            model_edge();
            tick();
            chk_all($sformatf("rand%0d", i), m_count, m_tc, m_wr);
        end
        $display("random phase done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
